// File: rtl/regfile_write_arbiter_if.sv
// Request/response bundle between the two writeback sources and the regfile
// write-port arbiter, including the registered write port and debug outputs.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              b_forced;
  logic [3:0]        wait_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, b_forced, wait_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, b_forced, wait_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Fixed-priority (A over B) arbiter for the single regfile write port, with a
// starvation counter that forces a B grant after MAX_WAIT lost contentions.
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [3:0]        CNT_MAX   = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  typedef enum logic [1:0] {
    GNT_NONE     = 2'd0,
    GNT_A        = 2'd1,
    GNT_B        = 2'd2,
    GNT_B_FORCED = 2'd3
  } grant_e;

  grant_e            grant_s;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              b_forced_q, b_forced_d;

  // Grant decision and starvation-counter next state.
  always_comb begin
    grant_s    = GNT_NONE;
    wait_cnt_d = wait_cnt_q;
    if (reset) begin
      grant_s    = GNT_NONE;
      wait_cnt_d = 4'd0;
    end else begin
      case ({bus.a_valid, bus.b_valid})
        2'b10: grant_s = GNT_A;
        2'b01: begin
          grant_s    = GNT_B;
          wait_cnt_d = 4'd0;
        end
        2'b11: begin
          if (wait_cnt_q >= CNT_MAX) begin
            grant_s    = GNT_B_FORCED;
            wait_cnt_d = 4'd0;
          end else begin
            grant_s    = GNT_A;
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        default: grant_s = GNT_NONE;
      endcase
    end
  end

  assign bus.a_ready = (grant_s == GNT_A);
  assign bus.b_ready = (grant_s == GNT_B) || (grant_s == GNT_B_FORCED);

  // Next write-port values; XZR writes are accepted but never enabled.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    b_forced_d = 1'b0;
    case (grant_s)
      GNT_A: begin
        wr_en_d   = (bus.a_addr != ZERO_ADDR);
        wr_addr_d = bus.a_addr;
        wr_data_d = bus.a_data;
      end
      GNT_B, GNT_B_FORCED: begin
        wr_en_d    = (bus.b_addr != ZERO_ADDR);
        wr_addr_d  = bus.b_addr;
        wr_data_d  = bus.b_data;
        b_forced_d = (grant_s == GNT_B_FORCED);
      end
      default: begin
        wr_en_d    = 1'b0;
        b_forced_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      b_forced_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      b_forced_q <= b_forced_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.b_forced = b_forced_q;
  assign bus.wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with MAX_WAIT=3 and XZR at 31.
module tb_regfile_write_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(
    .DATA_W(64), .ADDR_W(5), .MAX_WAIT(3), .ZERO_REG(31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_addr  = 5'd0;
    bus.a_data  = 64'd0;
    bus.b_valid = 1'b0;
    bus.b_addr  = 5'd0;
    bus.b_data  = 64'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'hAAAA;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 64'hBBBB;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready got a=%b b=%b exp a=0 b=0", bus.a_ready, bus.b_ready);
      end
      checks++;
      if (bus.wr_en !== 1'b0 || bus.wait_cnt !== 4'd0 || bus.b_forced !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got wr_en=%b wait=%0d forced=%b exp 0 0 0",
                 bus.wr_en, bus.wait_cnt, bus.b_forced);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_ready got a=%b b=%b exp a=1 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 64'hAAAA || bus.wait_cnt !== 4'd1) begin
      errors++;
      $display("FAIL release_write got en=%b addr=%0d data=%h wait=%0d exp 1 3 aaaa 1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.wait_cnt);
    end
  endtask

  task automatic test_single_port();
    apply_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'h1234;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got a=%b b=%b exp a=1 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'h1234 || bus.b_forced !== 1'b0) begin
      errors++;
      $display("FAIL single_write got en=%b addr=%0d data=%h forced=%b exp 1 5 1234 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.b_forced);
    end
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'h1234) begin
      errors++;
      $display("FAIL single_idle got en=%b addr=%0d data=%h exp 0 5 1234",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_contention();
    int  n;
    logic f;
    apply_reset();
    n = 1;
    bus.a_valid = 1'b1; bus.a_addr = 5'(n); bus.a_data = 64'(n);
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'h700;
    for (int k = 0; k < 8; k++) begin
      f = ((k % 4) == 3);
      #1;
      checks++;
      if (bus.wait_cnt !== 4'(k % 4) || bus.a_ready !== !f || bus.b_ready !== f) begin
        errors++;
        $display("FAIL contend_grant[%0d] got wait=%0d a=%b b=%b exp wait=%0d a=%b b=%b",
                 k, bus.wait_cnt, bus.a_ready, bus.b_ready, k % 4, !f, f);
      end
      tick();
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== (f ? 5'd7 : 5'(n)) ||
          bus.wr_data !== (f ? 64'h700 : 64'(n)) || bus.b_forced !== f) begin
        errors++;
        $display("FAIL contend_write[%0d] got en=%b addr=%0d data=%h forced=%b exp 1 %0d forced=%b",
                 k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.b_forced, f ? 7 : n, f);
      end
      if (!f) begin
        n++;
        bus.a_addr = 5'(n);
        bus.a_data = 64'(n);
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    apply_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd31; bus.a_data = 64'hFFFF;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2;  bus.b_data = 64'h22;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_ready got a=%b b=%b exp a=1 b=0", bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wait_cnt !== 4'd1 || bus.b_forced !== 1'b0) begin
      errors++;
      $display("FAIL zero_write got en=%b wait=%0d forced=%b exp 0 1 0",
               bus.wr_en, bus.wait_cnt, bus.b_forced);
    end
  endtask

  task automatic test_b_alone();
    apply_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 64'h2;
    bus.b_valid = 1'b1; bus.b_addr = 5'd8; bus.b_data = 64'h88;
    tick();
    bus.a_addr = 5'd3; bus.a_data = 64'h3;
    tick();
    checks++;
    if (bus.wait_cnt !== 4'd2 || bus.wr_addr !== 5'd3) begin
      errors++;
      $display("FAIL balone_wait got wait=%0d addr=%0d exp 2 3", bus.wait_cnt, bus.wr_addr);
    end
    bus.a_valid = 1'b0;
    #1;
    checks++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL balone_ready got a=%b b=%b exp a=0 b=1", bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.wait_cnt !== 4'd0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd8 ||
        bus.wr_data !== 64'h88 || bus.b_forced !== 1'b0) begin
      errors++;
      $display("FAIL balone_write got wait=%0d en=%b addr=%0d data=%h forced=%b exp 0 1 8 88 0",
               bus.wait_cnt, bus.wr_en, bus.wr_addr, bus.wr_data, bus.b_forced);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 64'h66;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 64'h99;
    tick();
    bus.a_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b0 || bus.wait_cnt !== 4'd1) begin
      errors++;
      $display("FAIL midreset_ready got a=%b b=%b wait=%0d exp 0 0 1",
               bus.a_ready, bus.b_ready, bus.wait_cnt);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wait_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midreset_drop got en=%b addr=%0d wait=%0d exp 0 0 0",
               bus.wr_en, bus.wr_addr, bus.wait_cnt);
    end
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr === 5'd9) begin
      errors++;
      $display("FAIL midreset_nowrite got en=%b addr=%0d exp en=0 addr!=9", bus.wr_en, bus.wr_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_single_port();
    test_contention();
    test_zero_reg();
    test_b_alone();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
